osc_meas_ctrl: RTL
==================

Name: osc_meas_ctrl

Overview:
- Measurement sequencer in the ref_clk domain, downstream of the GPIO ring-oscillator counter stage.
- Periodically requests a counter snapshot (osc_latch_req/osc_latch_ack) and captures osc_counter_latch.
- Outputs the modulo-2^32 delta between successive snapshots: ring-oscillator edges per gate window, i.e. a frequency measurement.
- Detects a stalled or halted oscillator via handshake timeout.

Parameters:
- GATE_CYCLES, 1000000: ref_clk cycles from the end of one handshake to the next request. Legal range 1..2^32-1.
- ACK_TIMEOUT, 1024: max ref_clk cycles spent waiting for osc_latch_ack to rise or fall before abort. Minimum 8.

Ports:
- ref_clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  level; 1 = run periodic measurements.
- osc_latch_req  out  1  snapshot request to the oscillator counter stage.
- osc_latch_ack  in  1  snapshot acknowledge; already synchronised to ref_clk.
- osc_counter_latch  in  32  frozen counter snapshot; stable while osc_latch_ack=1.
- meas_count  out  32  last delta (edges per window).
- meas_valid  out  1  one-cycle strobe when meas_count updates.
- meas_seq  out  16  measurement sequence number; increments with each meas_valid and wraps.
- timeout_err  out  1  sticky handshake-timeout flag.
- err_clr  in  1  single-cycle clear of timeout_err.

Behaviour:
- Reset (rst_n=0, async):
  - osc_latch_req=0, meas_count=0, meas_valid=0, meas_seq=0, timeout_err=0.
  - Internal prev=0, primed=0, state IDLE.
- All outputs are registered. Only osc_counter_latch is treated as multi-bit data, and it is sampled only while osc_latch_ack=1.
- States:
  - IDLE: req=0. On enable=1, go to REQ.
  - REQ: req=1; timer counts. On ack=1, capture snap=osc_counter_latch, then go to DROP.
  - DROP: req=0; timer counts. On ack=0, load the gate counter with GATE_CYCLES and go to GATE.
  - GATE: req=0; decrement each cycle. At 0, go to REQ. If enable=0, go to IDLE immediately.
- Capture (cycle ack first seen high in REQ):
  - If primed=0: set prev=snap, set primed=1, no strobe.
  - Else: meas_count=snap-prev (32-bit modulo, wrap-around correct), prev=snap.
  - meas_valid=1 for exactly one cycle, the cycle after capture; meas_seq increments in the same cycle.
- Timer: cleared on entry to REQ and to DROP. Expiry after ACK_TIMEOUT cycles without the awaited ack level triggers abort:
  - timeout_err=1, primed=0, req=0.
  - From REQ go to DROP.
  - From DROP go to IDLE.
- Window loss: the oscillator counter freezes while req is high, so each delta excludes edges during the handshake. Gate period = GATE_CYCLES plus the handshake duration. Documented; not compensated.
- enable=0 mid-handshake:
  - In REQ: deassert req, go to DROP. No capture unless ack was already high that cycle.
  - DROP completes normally, then goes to IDLE instead of GATE.
  - primed cleared on any enable fall.
- err_clr and a new timeout in the same cycle: set wins.
- No new request is issued until ack is observed low (four-phase handshake). req never rises while ack=1.
- Synchronous oscillator reset upstream (counter restart): the next delta may be a large wrap value. Software discards the first result after an oscillator reset.

Test Plan:
- Basic: GATE_CYCLES=100; model counter snapshots 1000 then 1250. Required: first handshake gives no strobe; second gives meas_valid pulse with meas_count=250 and meas_seq=1.
- Wrap: snapshots 0xFFFFFF00 then 0x00000010. Required: meas_count=0x110.
- Handshake ordering: model ack with 3-cycle latency. Required:
  - req stays high until ack=1 and drops the cycle after;
  - no req rise while ack=1;
  - next req exactly GATE_CYCLES cycles after ack fall is observed.
- Timeout: ack held 0. Required:
  - after ACK_TIMEOUT cycles req=0 and timeout_err=1;
  - next good handshake only primes (no strobe);
  - err_clr pulse clears timeout_err.
- enable drop: deassert enable during REQ (ack=0) and during GATE. Required:
  - req=0 within 1 cycle;
  - no meas_valid;
  - FSM in IDLE;
  - re-enable primes afresh.
- Reset mid-operation: assert rst_n=0 while req=1. Required: all outputs 0 asynchronously; after release, IDLE with meas_seq=0.

Source files
------------

// File: rtl/osc_meas_ctrl.sv
// osc_meas_ctrl: snapshot sequencer for the ring-oscillator counter, emitting edges-per-gate deltas with handshake timeout detection
module osc_meas_ctrl #(
  parameter logic [31:0] GATE_CYCLES = 32'd1000000,
  parameter logic [31:0] ACK_TIMEOUT = 32'd1024
) (
  input  logic        ref_clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        osc_latch_req,
  input  logic        osc_latch_ack,
  input  logic [31:0] osc_counter_latch,
  output logic [31:0] meas_count,
  output logic        meas_valid,
  output logic [15:0] meas_seq,
  output logic        timeout_err,
  input  logic        err_clr
);
  typedef enum logic [1:0] {IDLE, REQ, DROP, GATE} state_t;
  state_t state_q, state_d;
  logic [31:0] timer_q, timer_d, gate_q, gate_d, prev_q, prev_d, count_q, count_d;
  logic [15:0] seq_q, seq_d;
  logic req_q, req_d, valid_q, valid_d, primed_q, primed_d, err_q, err_d;
  logic capture, abort;
  always_comb begin
    capture = state_q == REQ && osc_latch_ack;
    abort = timer_q == ACK_TIMEOUT - 32'd1 &&
            ((state_q == REQ && !osc_latch_ack) || (state_q == DROP && osc_latch_ack));
    state_d = state_q;
    case (state_q)
      IDLE: state_d = enable && !osc_latch_ack ? REQ : IDLE;
      REQ: state_d = capture || abort || !enable ? DROP : REQ;
      DROP: state_d = !osc_latch_ack ? (enable ? GATE : IDLE) : abort ? IDLE : DROP;
      GATE: state_d = !enable ? IDLE : gate_q == 32'd1 ? REQ : GATE;
      default: state_d = IDLE;
    endcase
    timer_d = state_d != state_q ? 32'd0 : timer_q + 32'd1;
    gate_d = state_d == GATE && state_q != GATE ? GATE_CYCLES : gate_q - 32'd1;
    req_d = state_d == REQ;
    prev_d = capture ? osc_counter_latch : prev_q;
    valid_d = capture && primed_q;
    count_d = valid_d ? osc_counter_latch - prev_q : count_q;
    seq_d = seq_q + {15'd0, valid_d};
    primed_d = !enable || abort ? 1'b0 : capture ? 1'b1 : primed_q;
    err_d = abort ? 1'b1 : err_clr ? 1'b0 : err_q;
  end
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      gate_q <= '0;
      prev_q <= '0;
      count_q <= '0;
      seq_q <= '0;
      req_q <= 1'b0;
      valid_q <= 1'b0;
      primed_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      gate_q <= gate_d;
      prev_q <= prev_d;
      count_q <= count_d;
      seq_q <= seq_d;
      req_q <= req_d;
      valid_q <= valid_d;
      primed_q <= primed_d;
      err_q <= err_d;
    end
  end
  assign osc_latch_req = req_q;
  assign meas_count = count_q;
  assign meas_valid = valid_q;
  assign meas_seq = seq_q;
  assign timeout_err = err_q;
endmodule
